// File: rtl/adc_mp_seq.sv
// Multi-precision add/subtract sequencer driving one external 32-bit ADC32 adder, LS word first.
// Optional ADC_SEQ_ZERO_FLAG_EN adds a 'zero' output flagging an all-zero result.
module adc_mp_seq #(
   parameter int NWORDS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  sub,
   input  logic                  cin,
   input  logic [32*NWORDS-1:0]  a_in,
   input  logic [32*NWORDS-1:0]  b_in,
   output logic [31:0]           adc_A,
   output logic [31:0]           adc_B,
   output logic                  adc_C0,
   input  logic [32:0]           adc_S,
   output logic [32*NWORDS-1:0]  result,
   output logic                  cout,
   output logic                  overflow,
   output logic                  busy,
   output logic                  done
`ifdef ADC_SEQ_ZERO_FLAG_EN
   ,output logic                 zero
`endif
);

   localparam int W  = 32 * NWORDS;
   localparam int IW = $clog2(NWORDS);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state_reg, state_next;
   logic [W-1:0]    a_reg, b_reg;
   logic            sub_reg;
   logic            carry_reg;
   logic [IW-1:0]   idx_reg;
   logic            cout_reg, overflow_reg;
   logic [31:0]     a_word [NWORDS];
   logic [31:0]     b_word [NWORDS];
   logic [31:0]     result_word_reg [NWORDS];
   logic            accept, last_word, in_run;

   assign in_run    = (state_reg == RUN);
   assign accept    = start && ((state_reg == IDLE) || (state_reg == DONE));
   assign last_word = (idx_reg == IW'(NWORDS - 1));

   // Per-word views of the latched operands and per-word result registers.
   generate
      for (genvar gi = 0; gi < NWORDS; gi++) begin : g_word
         assign a_word[gi] = a_reg[gi*32 +: 32];
         assign b_word[gi] = b_reg[gi*32 +: 32];
         assign result[gi*32 +: 32] = result_word_reg[gi];

         always_ff @(posedge clk) begin
            if (rst)
               result_word_reg[gi] <= '0;
            else if (in_run && (idx_reg == IW'(gi)))
               result_word_reg[gi] <= adc_S[31:0];
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      busy       = 1'b0;
      done       = 1'b0;
      adc_A      = '0;
      adc_B      = '0;
      adc_C0     = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start)
               state_next = RUN;
         end
         RUN: begin
            busy   = 1'b1;
            adc_A  = a_word[idx_reg];
            adc_B  = sub_reg ? ~b_word[idx_reg] : b_word[idx_reg];
            adc_C0 = carry_reg;
            if (last_word)
               state_next = DONE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = start ? RUN : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Subtraction is A + ~B + 1, so the initial carry is forced to 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_reg        <= '0;
         b_reg        <= '0;
         sub_reg      <= 1'b0;
         carry_reg    <= 1'b0;
         idx_reg      <= '0;
         cout_reg     <= 1'b0;
         overflow_reg <= 1'b0;
      end else if (accept) begin
         a_reg     <= a_in;
         b_reg     <= b_in;
         sub_reg   <= sub;
         carry_reg <= sub ? 1'b1 : cin;
         idx_reg   <= '0;
      end else if (in_run) begin
         carry_reg <= adc_S[32];
         if (last_word) begin
            idx_reg      <= '0;
            cout_reg     <= adc_S[32];
            overflow_reg <= (adc_A[31] == adc_B[31]) && (adc_S[31] != adc_A[31]);
         end else begin
            idx_reg <= idx_reg + 1'b1;
         end
      end
   end

   assign cout     = cout_reg;
   assign overflow = overflow_reg;

`ifdef ADC_SEQ_ZERO_FLAG_EN
   logic zero_reg;

   // Word 0 restarts the accumulation so no clear is needed on start.
   always_ff @(posedge clk) begin
      if (rst)
         zero_reg <= 1'b0;
      else if (in_run)
         zero_reg <= (adc_S[31:0] == 32'd0) && ((idx_reg == '0) || zero_reg);
   end

   assign zero = zero_reg;
`endif

endmodule

// File: tb/tb_adc_mp_seq.sv
// Directed bench for adc_mp_seq (NWORDS=4) with a behavioural ADC32 adder attached.
module tb_adc_mp_seq;

   logic          clk;
   logic          rst;
   logic          start;
   logic          sub;
   logic          cin;
   logic [127:0]  a_in;
   logic [127:0]  b_in;
   logic [31:0]   adc_A;
   logic [31:0]   adc_B;
   logic          adc_C0;
   logic [32:0]   adc_S;
   logic [127:0]  result;
   logic          cout;
   logic          overflow;
   logic          busy;
   logic          done;
`ifdef ADC_SEQ_ZERO_FLAG_EN
   logic          zero;
`endif

   int n_cmp;
   int n_err;

   adc_mp_seq #(.NWORDS(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .sub      (sub),
      .cin      (cin),
      .a_in     (a_in),
      .b_in     (b_in),
      .adc_A    (adc_A),
      .adc_B    (adc_B),
      .adc_C0   (adc_C0),
      .adc_S    (adc_S),
      .result   (result),
      .cout     (cout),
      .overflow (overflow),
      .busy     (busy),
      .done     (done)
`ifdef ADC_SEQ_ZERO_FLAG_EN
      ,.zero    (zero)
`endif
   );

   // External combinational ADC32
   assign adc_S = {1'b0, adc_A} + {1'b0, adc_B} + {32'd0, adc_C0};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Caller is at a negedge; returns at the negedge of the DONE cycle (or timeout).
   task automatic run_op(input logic [127:0] a, input logic [127:0] b,
                         input logic s, input logic c, output int lat);
      a_in = a; b_in = b; sub = s; cin = c; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      while (done !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      $display("op a=%h b=%h sub=%0d cin=%0d -> result=%h cout=%0d ovf=%0d lat=%0d",
               a, b, s, c, result, cout, overflow, lat);
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a_in = '0; b_in = '0;
      repeat (3) @(negedge clk);
      n_cmp++; if (result !== 128'd0) begin n_err++; $display("FAIL reset_result: got %h expected 0", result); end
      n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL reset_cout: got %b expected 0", cout); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
      n_cmp++; if ({adc_A, adc_B, adc_C0} !== 65'd0) begin n_err++; $display("FAIL reset_adc: got %h/%h/%b expected 0", adc_A, adc_B, adc_C0); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_carry_ripple();
      int lat;
      @(negedge clk);
      run_op(128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'd1, 1'b0, 1'b0, lat);
      n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL ripple_latency: got %0d expected 5", lat); end
      n_cmp++; if (result !== 128'h00000001_00000000_00000000_00000000) begin n_err++; $display("FAIL ripple_result: got %h expected 00000001_00000000_00000000_00000000", result); end
      n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL ripple_cout: got %b expected 0", cout); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ripple_ovf: got %b expected 0", overflow); end
      @(negedge clk);
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL done_one_cycle: got %b expected 0", done); end
      n_cmp++; if (result !== 128'h00000001_00000000_00000000_00000000) begin n_err++; $display("FAIL ripple_hold: got %h expected held result", result); end
   endtask

   task automatic test_carry_in();
      int lat;
      @(negedge clk);
      run_op({128{1'b1}}, 128'd0, 1'b0, 1'b1, lat);
      n_cmp++; if (result !== 128'd0) begin n_err++; $display("FAIL cin_result: got %h expected 0", result); end
      n_cmp++; if (cout !== 1'b1) begin n_err++; $display("FAIL cin_cout: got %b expected 1", cout); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL cin_ovf: got %b expected 0", overflow); end
`ifdef ADC_SEQ_ZERO_FLAG_EN
      n_cmp++; if (zero !== 1'b1) begin n_err++; $display("FAIL cin_zero: got %b expected 1", zero); end
`endif
   endtask

   task automatic test_subtract();
      int lat;
      @(negedge clk);
      run_op(128'd5, 128'd7, 1'b1, 1'b1, lat);
      n_cmp++; if (result !== 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE) begin n_err++; $display("FAIL sub_neg_result: got %h expected ...FFFE", result); end
      n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL sub_neg_cout: got %b expected 0", cout); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL sub_neg_ovf: got %b expected 0", overflow); end
`ifdef ADC_SEQ_ZERO_FLAG_EN
      n_cmp++; if (zero !== 1'b0) begin n_err++; $display("FAIL sub_neg_zero: got %b expected 0", zero); end
`endif
      @(negedge clk);
      run_op(128'd7, 128'd5, 1'b1, 1'b0, lat);
      n_cmp++; if (result !== 128'd2) begin n_err++; $display("FAIL sub_pos_result: got %h expected 2", result); end
      n_cmp++; if (cout !== 1'b1) begin n_err++; $display("FAIL sub_pos_cout: got %b expected 1", cout); end
   endtask

   task automatic test_overflow();
      int lat;
      @(negedge clk);
      run_op(128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'd1, 1'b0, 1'b0, lat);
      n_cmp++; if (result !== 128'h80000000_00000000_00000000_00000000) begin n_err++; $display("FAIL ovf_result: got %h expected 80000000_0..0", result); end
      n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
      n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL ovf_cout: got %b expected 0", cout); end
   endtask

   task automatic test_back_to_back();
      int lat;
      @(negedge clk);
      a_in = 128'd5; b_in = 128'd7; sub = 1'b0; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      a_in = 128'd100; b_in = 128'd200; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 3;
      while (done !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      $display("op a=5 b=7 with ignored start -> result=%h lat=%0d", result, lat);
      n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL ignored_start_latency: got %0d expected 5", lat); end
      n_cmp++; if (result !== 128'd12) begin n_err++; $display("FAIL ignored_start_result: got %h expected 12", result); end
      // Start in the DONE cycle
      a_in = 128'hA5A5A5A5; b_in = 128'hA5A5A5A5; sub = 1'b0; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_busy: got %b expected 1", busy); end
      n_cmp++; if ({adc_A, adc_B, adc_C0} !== {32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0}) begin n_err++; $display("FAIL b2b_word0_drive: got %h/%h/%b expected a5a5a5a5/a5a5a5a5/0", adc_A, adc_B, adc_C0); end
      @(negedge clk);
      n_cmp++; if (result[31:0] !== 32'h4B4B4B4A) begin n_err++; $display("FAIL b2b_low_word: got %h expected 4b4b4b4a", result[31:0]); end
      n_cmp++; if (adc_C0 !== 1'b1) begin n_err++; $display("FAIL b2b_carry_word1: got %b expected 1", adc_C0); end
      lat = 2;
      while (done !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      $display("op a=a5a5a5a5 b=a5a5a5a5 back-to-back -> result=%h lat=%0d", result, lat);
      n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL b2b_latency: got %0d expected 5", lat); end
      n_cmp++; if (result !== 128'h1_4B4B4B4A) begin n_err++; $display("FAIL b2b_result: got %h expected 1_4b4b4b4a", result); end
   endtask

   task automatic test_reset_mid_run();
      int lat;
      int done_seen;
      @(negedge clk);
      a_in = 128'h11111111_22222222_33333333_44444444; b_in = 128'd1; sub = 1'b0; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b expected 0", busy); end
      n_cmp++; if (result !== 128'd0) begin n_err++; $display("FAIL midrst_result: got %h expected 0", result); end
      n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL midrst_cout: got %b expected 0", cout); end
      n_cmp++; if (adc_A !== 32'd0) begin n_err++; $display("FAIL midrst_adc_A: got %h expected 0", adc_A); end
      rst = 1'b0;
      done_seen = 0;
      for (int i = 0; i < 6; i++) begin
         if (done === 1'b1) done_seen++;
         @(negedge clk);
      end
      n_cmp++; if (done_seen !== 0) begin n_err++; $display("FAIL midrst_no_done: got %0d pulses expected 0", done_seen); end
      run_op(128'd3, 128'd4, 1'b0, 1'b0, lat);
      n_cmp++; if (lat !== 5) begin n_err++; $display("FAIL after_rst_latency: got %0d expected 5", lat); end
      n_cmp++; if (result !== 128'd7) begin n_err++; $display("FAIL after_rst_result: got %h expected 7", result); end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a_in = '0; b_in = '0;
      test_reset();
      test_carry_ripple();
      test_carry_in();
      test_subtract();
      test_overflow();
      test_back_to_back();
      test_reset_mid_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/adc_mp_seq.md
Name: adc_mp_seq

Overview:
- Multi-precision add/subtract controller that time-shares one external 32-bit ADC32 adder (A, B, C0 in; 33-bit S out) across NWORDS 32-bit words.
- Processes one word per clock, least-significant word first, chaining each word's carry (S[32]) into the next word's C0.
- Sits beside the ALU in the datapath for wide-operand arithmetic; ADC32 stays a separate combinational instance driven by this block.

Parameters:
- NWORDS, 4, number of 32-bit words per operand (legal 2..8); operand width W = 32*NWORDS.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; accepted only in IDLE or DONE.
- sub  in  1  0 = A+B+cin; 1 = A-B (two's complement).
- cin  in  1  carry into word 0 for add; ignored when sub=1.
- a_in  in  W  operand A, sampled on the accepted start.
- b_in  in  W  operand B, sampled on the accepted start.
- adc_A  out  32  to ADC32.A: current word of latched A.
- adc_B  out  32  to ADC32.B: current word of latched B, bitwise inverted when sub=1.
- adc_C0  out  1  to ADC32.C0: chained carry.
- adc_S  in  33  from ADC32.S.
- result  out  W  sum/difference; valid while done=1 and held until the next accepted start.
- cout  out  1  final carry (sub: 1 = no borrow).
- overflow  out  1  signed overflow of the full W-bit operation.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse in DONE.

Behaviour:
- Reset: state=IDLE; result=0, cout=0, overflow=0, busy=0, done=0, word index=0, carry reg=0; adc_A/adc_B/adc_C0 driven 0.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN on start. Latch a_in, b_in and sub; idx=0; carry reg = sub ? 1 : cin.
- RUN, each cycle:
  - adc_A = A[idx]; adc_B = sub ? ~B[idx] : B[idx]; adc_C0 = carry reg.
  - At the clock edge: result[idx] = adc_S[31:0]; carry reg = adc_S[32]; idx++.
  - When idx = NWORDS-1 at the edge: cout = adc_S[32]; overflow = (a_msb == b'_msb) && (adc_S[31] != a_msb), where b' is the possibly inverted B; -> DONE.
- DONE: done=1 for exactly one cycle.
  - Without start -> IDLE.
  - With start -> RUN, new operands latched (back-to-back operation).
- Latency: done asserts NWORDS+1 cycles after the start edge, i.e. NWORDS compute cycles plus the DONE cycle. A new start may be accepted in the DONE cycle, giving a throughput of one operation per NWORDS+1 cycles.
- start while busy is ignored: no effect, no queuing.
- result words not yet written in the current operation hold their previous values until written; the full result is guaranteed only when done=1.
- rst mid-operation: return to IDLE with all outputs at their reset values on the next edge; the partial result is discarded.
- ADC32 is combinational with zero cycles of latency; the block must not register adc_S before use.
- adc_A, adc_B and adc_C0 are 0 outside RUN.

Optional Feature:
- Macro ADC_SEQ_ZERO_FLAG_EN.
- When defined: adds output port zero (1 bit). It is the AND of per-word "adc_S[31:0]==0" accumulated across RUN, updated together with result. It is valid with done and resets to 0.
- When undefined: no zero port and no accumulation logic.

Test Plan (NWORDS=4):
- Carry ripple: add, A=128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, B=1, cin=0 -> result=128'h00000001_00000000_00000000_00000000, cout=0, overflow=0; done exactly 5 cycles after start.
- Carry-in: add, A=all ones, B=0, cin=1 -> result=0, cout=1, overflow=0, zero=1 (with ADC_SEQ_ZERO_FLAG_EN).
- Subtract: sub=1, A=5, B=7 -> result=128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE, cout=0, overflow=0; then A=7, B=5 -> result=2, cout=1.
- Signed overflow: add, A=128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, B=1 -> result=128'h80000000_00000000_00000000_00000000, overflow=1, cout=0.
- Handshake: start pulsed again 2 cycles into RUN -> ignored, first result unchanged. Start in the DONE cycle with A=B=32'hA5A5A5A5 -> result low word 32'h4B4B4B4A, carry 1 into word 1, next done 5 cycles later.
- Reset mid-run: assert rst on the 3rd RUN cycle -> busy=0, result=0, no done pulse; a subsequent start completes normally.
